// File: rtl/extremum_tracker_32.sv
// Streaming per-frame max/min tracker. It reports the value and first-occurrence index of
// the frame's max and min, plus a saturating beat count. All decisions use two cmp_32 instances.

module cmp_32 (
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        GT,
    output logic        LT,
    output logic        EQ
);
    assign GT = A > B;
    assign LT = A < B;
    assign EQ = A == B;
endmodule

module extremum_tracker_32 #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             S_VALID,
    output logic             S_READY,
    input  logic [31:0]      S_DATA,
    input  logic             S_LAST,
    output logic             M_VALID,
    input  logic             M_READY,
    output logic [31:0]      M_MAX,
    output logic [31:0]      M_MIN,
    output logic [CNT_W-1:0] M_MAX_IDX,
    output logic [CNT_W-1:0] M_MIN_IDX,
    output logic [CNT_W-1:0] M_COUNT,
    output logic             M_OVF
);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state_q, state_d;
    logic [31:0]       max_q, max_d, min_q, min_d;
    logic [CNT_W-1:0]  max_idx_q, max_idx_d, min_idx_q, min_idx_d, cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [31:0]       m_max_q, m_max_d, m_min_q, m_min_d;
    logic [CNT_W-1:0]  m_max_idx_q, m_max_idx_d, m_min_idx_q, m_min_idx_d, m_count_q, m_count_d;
    logic              m_ovf_q, m_ovf_d;
    logic              accept;
    logic [1:0]        gt, lt, eq;

    // Instance 0 compares against the running max, instance 1 against the running min.
    for (genvar g = 0; g < 2; g++) begin : g_cmp
        cmp_32 u_cmp (
            .A  (S_DATA),
            .B  ((g == 0) ? max_q : min_q),
            .GT (gt[g]),
            .LT (lt[g]),
            .EQ (eq[g])
        );
    end

    assign S_READY = (state_q != HOLD);
    assign M_VALID = (state_q == HOLD);
    assign accept  = S_VALID & S_READY;

    always_comb begin
        state_d     = state_q;
        max_d       = max_q;
        min_d       = min_q;
        max_idx_d   = max_idx_q;
        min_idx_d   = min_idx_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        m_max_d     = m_max_q;
        m_min_d     = m_min_q;
        m_max_idx_d = m_max_idx_q;
        m_min_idx_d = m_min_idx_q;
        m_count_d   = m_count_q;
        m_ovf_d     = m_ovf_q;
        case (state_q)
            IDLE: if (accept) begin
                max_d     = S_DATA;
                min_d     = S_DATA;
                max_idx_d = '0;
                min_idx_d = '0;
                cnt_d     = 1;
                ovf_d     = 1'b0;
                state_d   = S_LAST ? HOLD : ACCUM;
            end
            ACCUM: if (accept) begin
                // Ties never move the extremum, so the first occurrence keeps its index.
                if (gt[0] && !eq[0]) begin
                    max_d     = S_DATA;
                    max_idx_d = cnt_q;
                end
                if (lt[1] && !eq[1]) begin
                    min_d     = S_DATA;
                    min_idx_d = cnt_q;
                end
                if (cnt_q == CNT_MAX) ovf_d = 1'b1;
                else                  cnt_d = cnt_q + 1'b1;
                if (S_LAST) state_d = HOLD;
            end
            HOLD: if (M_READY) begin
                state_d = IDLE;
                ovf_d   = 1'b0;
                m_ovf_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        // Result registers capture the final-beat-updated values on HOLD entry only.
        if (state_q != HOLD && state_d == HOLD) begin
            m_max_d     = max_d;
            m_min_d     = min_d;
            m_max_idx_d = max_idx_d;
            m_min_idx_d = min_idx_d;
            m_count_d   = cnt_d;
            m_ovf_d     = ovf_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            max_q       <= '0;
            min_q       <= '0;
            max_idx_q   <= '0;
            min_idx_q   <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            m_max_q     <= '0;
            m_min_q     <= '0;
            m_max_idx_q <= '0;
            m_min_idx_q <= '0;
            m_count_q   <= '0;
            m_ovf_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            max_q       <= max_d;
            min_q       <= min_d;
            max_idx_q   <= max_idx_d;
            min_idx_q   <= min_idx_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            m_max_q     <= m_max_d;
            m_min_q     <= m_min_d;
            m_max_idx_q <= m_max_idx_d;
            m_min_idx_q <= m_min_idx_d;
            m_count_q   <= m_count_d;
            m_ovf_q     <= m_ovf_d;
        end
    end

    assign M_MAX     = m_max_q;
    assign M_MIN     = m_min_q;
    assign M_MAX_IDX = m_max_idx_q;
    assign M_MIN_IDX = m_min_idx_q;
    assign M_COUNT   = m_count_q;
    assign M_OVF     = m_ovf_q;
endmodule
